// File: rtl/zle_enc_if.sv
// Stream bundle for the zero run-length encoder: input word stream and output token stream.
// Ports (signals):
//   i_d, i_eos, i_valid, i_ready : input stream (producer -> encoder)
//   o_d, o_eos, o_valid, o_ready : output token stream (encoder -> packer)
// Modports:
//   master : producer/consumer side (drives inputs and o_ready)
//   slave  : encoder side
interface zle_enc_if #(
  parameter int unsigned DW = 3,
  parameter int unsigned CW = 4
);
  localparam int unsigned OW = ((DW > CW) ? DW : CW) + 1;

  logic [DW-1:0] i_d;
  logic          i_eos;
  logic          i_valid;
  logic          i_ready;
  logic [OW-1:0] o_d;
  logic          o_eos;
  logic          o_valid;
  logic          o_ready;

  modport master (
    output i_d, i_eos, i_valid, o_ready,
    input  i_ready, o_d, o_eos, o_valid
  );

  modport slave (
    input  i_d, i_eos, i_valid, o_ready,
    output i_ready, o_d, o_eos, o_valid
  );
endinterface

// File: rtl/zle_enc_param.sv
// Parametrised zero run-length encoder with end-of-stream flush.
// Nonzero words pass as literal tokens {0, word}; runs of zero words collapse into a single
// run token {1, length}, length 1..2**CW-1. A run is flushed on i_eos so nothing is lost.
// Ports:
//   clock       : single clock, rising edge
//   reset       : synchronous, active-high
//   bus (slave) : i_d/i_eos/i_valid/i_ready input stream, o_d/o_eos/o_valid/o_ready tokens
//   stat_zeros  : (ZLE_ENC_STATS_EN only) zero words accepted, saturating
//   stat_tokens : (ZLE_ENC_STATS_EN only) output transfers, saturating
// Optional feature macro: ZLE_ENC_STATS_EN
module zle_enc_param #(
  parameter int unsigned DW = 3,
  parameter int unsigned CW = 4
) (
  input  logic        clock,
  input  logic        reset,
  zle_enc_if.slave    bus
`ifdef ZLE_ENC_STATS_EN
  ,
  output logic [15:0] stat_zeros,
  output logic [15:0] stat_tokens
`endif
);

  localparam int unsigned OW = ((DW > CW) ? DW : CW) + 1;
  localparam logic [CW-1:0] MaxRun = '1;

  typedef enum logic [1:0] {StIdle, StRun, StPend} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] pend_d_q, pend_d_d;
  logic          pend_eos_q, pend_eos_d;
  logic [OW-1:0] o_d_q;
  logic          o_eos_q, o_valid_q;

  logic          slot_free, accept, word_zero;
  logic          emit, emit_eos;
  logic [OW-1:0] emit_tok;
  logic [CW-1:0] cnt_inc;

  function automatic logic [OW-1:0] lit_tok(input logic [DW-1:0] w);
    logic [OW-1:0] t;
    t = '0;
    t[DW-1:0] = w;
    return t;
  endfunction

  function automatic logic [OW-1:0] run_tok(input logic [CW-1:0] len);
    logic [OW-1:0] t;
    t = '0;
    t[OW-1] = 1'b1;
    t[CW-1:0] = len;
    return t;
  endfunction

  assign slot_free   = !o_valid_q || bus.o_ready;
  assign bus.i_ready = !reset && (state_q != StPend) && slot_free;
  assign accept      = bus.i_valid && bus.i_ready;
  assign word_zero   = (bus.i_d == '0);
  // cnt_q stays below MaxRun while in StRun, so this never wraps.
  assign cnt_inc     = cnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pend_d_d   = pend_d_q;
    pend_eos_d = pend_eos_q;
    emit       = 1'b0;
    emit_eos   = 1'b0;
    emit_tok   = '0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (!word_zero) begin
            emit     = 1'b1;
            emit_tok = lit_tok(bus.i_d);
            emit_eos = bus.i_eos;
          end else if (bus.i_eos) begin
            emit     = 1'b1;
            emit_tok = run_tok({{(CW-1){1'b0}}, 1'b1});
            emit_eos = 1'b1;
          end else begin
            cnt_d   = {{(CW-1){1'b0}}, 1'b1};
            state_d = StRun;
          end
        end
      end
      StRun: begin
        if (accept) begin
          if (word_zero) begin
            if (bus.i_eos || (cnt_inc == MaxRun)) begin
              emit     = 1'b1;
              emit_tok = run_tok(cnt_inc);
              emit_eos = bus.i_eos;
              cnt_d    = '0;
              state_d  = StIdle;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            // Close the run now; the literal waits one cycle for the slot.
            emit       = 1'b1;
            emit_tok   = run_tok(cnt_q);
            emit_eos   = 1'b0;
            pend_d_d   = bus.i_d;
            pend_eos_d = bus.i_eos;
            cnt_d      = '0;
            state_d    = StPend;
          end
        end
      end
      StPend: begin
        if (slot_free) begin
          emit     = 1'b1;
          emit_tok = lit_tok(pend_d_q);
          emit_eos = pend_eos_q;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      pend_d_q   <= '0;
      pend_eos_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_d_q   <= pend_d_d;
      pend_eos_q <= pend_eos_d;
    end
  end

  // Single output slot; emit only happens when slot_free, so a drain and a new token
  // can share one cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      o_d_q     <= '0;
      o_eos_q   <= 1'b0;
      o_valid_q <= 1'b0;
    end else if (emit) begin
      o_d_q     <= emit_tok;
      o_eos_q   <= emit_eos;
      o_valid_q <= 1'b1;
    end else if (bus.o_ready) begin
      o_valid_q <= 1'b0;
    end
  end

  assign bus.o_d     = o_d_q;
  assign bus.o_eos   = o_eos_q;
  assign bus.o_valid = o_valid_q;

`ifdef ZLE_ENC_STATS_EN
  logic [15:0] stat_zeros_q, stat_tokens_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      stat_zeros_q  <= '0;
      stat_tokens_q <= '0;
    end else begin
      if (accept && word_zero && (stat_zeros_q != 16'hFFFF)) begin
        stat_zeros_q <= stat_zeros_q + 16'd1;
      end
      if (o_valid_q && bus.o_ready && (stat_tokens_q != 16'hFFFF)) begin
        stat_tokens_q <= stat_tokens_q + 16'd1;
      end
    end
  end

  assign stat_zeros  = stat_zeros_q;
  assign stat_tokens = stat_tokens_q;
`endif

endmodule

// File: tb/tb_zle_enc_param.sv
module tb_zle_enc_param;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  zle_enc_if #(.DW(3), .CW(4)) bus ();

`ifdef ZLE_ENC_STATS_EN
  logic [15:0] stat_zeros, stat_tokens;
`endif

  zle_enc_param #(.DW(3), .CW(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
`ifdef ZLE_ENC_STATS_EN
    ,
    .stat_zeros  (stat_zeros),
    .stat_tokens (stat_tokens)
`endif
  );

  typedef struct packed {
    logic [4:0] d;
    logic       e;
  } tok_t;

  typedef struct {
    logic [2:0] w;
    logic       e;
    int         n;
    tok_t       t0;
    tok_t       t1;
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  tok_t exp_q[$];
  vec_t vecs[64];
  int   n_vec = 0;

  function automatic void add_vec(input logic [2:0] w, input logic e, input int n,
                                  input logic [4:0] d0, input logic e0,
                                  input logic [4:0] d1, input logic e1);
    vecs[n_vec].w  = w;
    vecs[n_vec].e  = e;
    vecs[n_vec].n  = n;
    vecs[n_vec].t0 = '{d: d0, e: e0};
    vecs[n_vec].t1 = '{d: d1, e: e1};
    n_vec++;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, req);
    end
  endtask

  // Scoreboard: every output transfer must match the oldest expected token.
  always @(negedge clock) begin
    if (!reset && bus.o_valid && bus.o_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL token: unexpected o_d=0x%0h o_eos=%0b", bus.o_d, bus.o_eos);
      end else begin
        tok_t t;
        t = exp_q.pop_front();
        if (bus.o_d !== t.d || bus.o_eos !== t.e) begin
          bad++;
          $display("FAIL token: got o_d=0x%0h o_eos=%0b want o_d=0x%0h o_eos=%0b",
                   bus.o_d, bus.o_eos, t.d, t.e);
        end
      end
    end
  end

  // Present one word and hold it until it is accepted (bounded).
  task automatic send(input logic [2:0] w, input logic e);
    bit ok;
    ok = 1'b0;
    bus.i_d     = w;
    bus.i_eos   = e;
    bus.i_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      if (bus.i_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clock);
    #1;
    bus.i_valid = 1'b0;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL send_timeout: word 0x%0h not accepted", w);
    end
  endtask

  task automatic push(input logic [4:0] d, input logic e);
    exp_q.push_back('{d: d, e: e});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_d     = '0;
    bus.i_eos   = 1'b0;
    bus.i_valid = 1'b0;
    bus.o_ready = 1'b1;

    // Vector table: each word with the tokens it causes.
    add_vec(3'd5, 1'b0, 1, 5'h05, 1'b0, 5'h00, 1'b0);
    add_vec(3'd3, 1'b0, 1, 5'h03, 1'b0, 5'h00, 1'b0);
    add_vec(3'd7, 1'b0, 1, 5'h07, 1'b0, 5'h00, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      add_vec(3'd0, 1'b0, (i == 15) ? 1 : 0, 5'h1F, 1'b0, 5'h00, 1'b0);
    end
    add_vec(3'd1, 1'b0, 2, 5'h15, 1'b0, 5'h01, 1'b0);
    add_vec(3'd0, 1'b0, 0, 5'h00, 1'b0, 5'h00, 1'b0);
    add_vec(3'd0, 1'b1, 1, 5'h12, 1'b1, 5'h00, 1'b0);
    add_vec(3'd4, 1'b0, 1, 5'h04, 1'b0, 5'h00, 1'b0);
    add_vec(3'd0, 1'b1, 1, 5'h11, 1'b1, 5'h00, 1'b0);
    add_vec(3'd6, 1'b1, 1, 5'h06, 1'b1, 5'h00, 1'b0);
    add_vec(3'd0, 1'b0, 0, 5'h00, 1'b0, 5'h00, 1'b0);
    add_vec(3'd3, 1'b1, 2, 5'h11, 1'b0, 5'h03, 1'b1);
    for (int i = 1; i <= 14; i++) begin
      add_vec(3'd0, 1'b0, 0, 5'h00, 1'b0, 5'h00, 1'b0);
    end
    add_vec(3'd0, 1'b1, 1, 5'h1F, 1'b1, 5'h00, 1'b0);

    // Reset state.
    repeat (3) @(posedge clock);
    #1;
    chk("reset_o_valid", {31'd0, bus.o_valid}, 32'd0);
    chk("reset_o_d", {27'd0, bus.o_d}, 32'd0);
    chk("reset_o_eos", {31'd0, bus.o_eos}, 32'd0);
    chk("reset_i_ready", {31'd0, bus.i_ready}, 32'd0);
    reset = 1'b0;
    #1;
    chk("post_reset_i_ready", {31'd0, bus.i_ready}, 32'd1);

    // Literals, one per cycle, latency 1.
    push(5'h05, 1'b0);
    push(5'h03, 1'b0);
    push(5'h07, 1'b0);
    bus.i_d = 3'd5;
    bus.i_eos = 1'b0;
    bus.i_valid = 1'b1;
    @(posedge clock);
    #1;
    chk("lat_valid", {31'd0, bus.o_valid}, 32'd1);
    chk("lat_lit5", {27'd0, bus.o_d}, 32'h05);
    bus.i_d = 3'd3;
    @(posedge clock);
    #1;
    chk("lat_lit3", {27'd0, bus.o_d}, 32'h03);
    bus.i_d = 3'd7;
    @(posedge clock);
    #1;
    chk("lat_lit7", {27'd0, bus.o_d}, 32'h07);
    bus.i_valid = 1'b0;
    @(posedge clock);
    #1;
    chk("lat_idle_valid", {31'd0, bus.o_valid}, 32'd0);

    // Table-driven stream.
    for (int i = 0; i < n_vec; i++) begin
      if (vecs[i].n > 0) exp_q.push_back(vecs[i].t0);
      if (vecs[i].n > 1) exp_q.push_back(vecs[i].t1);
      send(vecs[i].w, vecs[i].e);
    end

    // Run closed by a literal: PEND blocks input for one cycle.
    push(5'h13, 1'b0);
    push(5'h02, 1'b0);
    push(5'h04, 1'b0);
    send(3'd0, 1'b0);
    send(3'd0, 1'b0);
    send(3'd0, 1'b0);
    bus.i_d = 3'd2;
    bus.i_valid = 1'b1;
    @(negedge clock);
    chk("pend_pre_ready", {31'd0, bus.i_ready}, 32'd1);
    @(posedge clock);
    #1;
    bus.i_d = 3'd4;
    @(negedge clock);
    chk("pend_ready_low", {31'd0, bus.i_ready}, 32'd0);
    chk("pend_run_tok", {27'd0, bus.o_d}, 32'h13);
    @(posedge clock);
    #1;
    @(negedge clock);
    chk("pend_ready_back", {31'd0, bus.i_ready}, 32'd1);
    chk("pend_lit_tok", {27'd0, bus.o_d}, 32'h02);
    @(posedge clock);
    #1;
    bus.i_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;

    // Backpressure: held token stays stable, input stalls, nothing lost.
    push(5'h05, 1'b0);
    push(5'h06, 1'b1);
    bus.o_ready = 1'b0;
    bus.i_d = 3'd5;
    bus.i_eos = 1'b0;
    bus.i_valid = 1'b1;
    @(posedge clock);
    #1;
    bus.i_d = 3'd6;
    bus.i_eos = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", {31'd0, bus.o_valid}, 32'd1);
      chk("bp_o_d", {27'd0, bus.o_d}, 32'h05);
      chk("bp_o_eos", {31'd0, bus.o_eos}, 32'd0);
      chk("bp_i_ready", {31'd0, bus.i_ready}, 32'd0);
      @(posedge clock);
      #1;
    end
    bus.o_ready = 1'b1;
    @(negedge clock);
    chk("bp_release_ready", {31'd0, bus.i_ready}, 32'd1);
    @(posedge clock);
    #1;
    bus.i_valid = 1'b0;
    bus.i_eos = 1'b0;
    repeat (3) @(posedge clock);
    #1;

    // Reset in the middle of a run discards it.
    for (int k = 0; k < 6; k++) send(3'd0, 1'b0);
    reset = 1'b1;
    @(negedge clock);
    chk("rst_run_i_ready", {31'd0, bus.i_ready}, 32'd0);
    @(posedge clock);
    #1;
    chk("rst_run_o_valid", {31'd0, bus.o_valid}, 32'd0);
    chk("rst_run_i_ready2", {31'd0, bus.i_ready}, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    chk("rst_run_o_valid_after", {31'd0, bus.o_valid}, 32'd0);
    push(5'h03, 1'b0);
    send(3'd3, 1'b0);

    // Drain the scoreboard (bounded).
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(posedge clock);
    repeat (3) @(posedge clock);
    #1;
    chk("drain_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
